result_display_unit: RTL and testbench
======================================

// Module: result_display_unit
// PURPOSE
//  Output-side companion of the byte-serial operand loader: captures the 32-bit result dataR and presents
//  it one byte at a time on the four 7-segment displays. The user steps bytes 0..3 with the enter button.
//  Sits between the datapath result bus and the board displays.
// PARAMETERS
//  SCROLL_CYCLES  50_000_000  cycles per automatic byte advance (used only with AUTOSCROLL_EN)
//  CNT_W          32          width of the scroll counter; must hold SCROLL_CYCLES-1
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   asynchronous, active-low reset (reset==0 clears all state)
//  enter        in   1   raw button level, asynchronous to clk
//  dataR        in   32  result word from datapath
//  dataR_valid  in   1   1-cycle strobe: capture dataR
//  byte_sel     out  2   index of byte currently displayed
//  showing      out  1   1 while in SHOW state
//  viewed_all   out  1   1-cycle pulse when stepping past byte 3
//  disp3..disp0 out  7   each bit {g,f,e,d,c,b,a}, active-low; disp3 leftmost
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, shadow=0, byte_sel=0, sync/edge flops=0, scroll cnt=0,
//   viewed_all=0, showing=0, disp3..disp0=7'h7F (blank).
//  Enter path: 2-flop synchronizer then edge detect: step = sync2 & ~sync2_q.
//   Enter high before edge k -> step high in cycle after edge k+1 -> byte_sel updates at edge k+2.
//   Holding enter high gives exactly one step; one step per rising edge of enter.
//  States: IDLE -> SHOW on dataR_valid. SHOW -> SHOW (no exit except reset).
//   dataR_valid in any state: shadow<=dataR, byte_sel<=0, cnt<=0, state<=SHOW.
//   step in SHOW: byte_sel<=byte_sel+1 (2-bit wrap 3->0); if byte_sel==3, viewed_all=1 for exactly one cycle.
//   step in IDLE: ignored, no output change.
//   dataR_valid and step in same cycle: load wins, byte_sel=0, no viewed_all.
//   dataR changes without dataR_valid: no effect (display uses shadow only).
//  Displays: combinational decode of registered state, valid the same cycle the state changes.
//   IDLE: all four = 7'h7F.
//   SHOW: disp3=hex(byte_sel), disp2='r' (7'h2F),
//    disp1=hex(shadow[8*byte_sel+7 -: 4]), disp0=hex(shadow[8*byte_sel +: 4]).
//  Hex table: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  Reset asserted mid-operation: immediate return to reset values; the next dataR_valid restarts normally.
// CONFIGURATION
//  AUTOSCROLL_EN defined: in SHOW, cnt increments each cycle. When cnt==SCROLL_CYCLES-1, cnt<=0 and
//   the byte advances exactly as for a step, including viewed_all on 3->0.
//   A manual step or dataR_valid clears cnt. Manual step and auto-advance in the same cycle give a single advance.
//   cnt is held at 0 in IDLE.
//  AUTOSCROLL_EN undefined: no counter logic; only enter advances; SCROLL_CYCLES and CNT_W unused.
// TESTING
//  1 Reset held low 3 cycles, then released -> disp3..0=7F, showing=0, byte_sel=0, viewed_all=0.
//  2 dataR=32'hA1B2C3F0, dataR_valid 1 cycle -> showing=1, disp3=40, disp2=2F, disp1=0E (F), disp0=40 (0).
//  3 From 2: four enter presses (high 5 cycles each, low 5 cycles) -> byte_sel steps 1,2,3,0;
//    byte 3 shows disp1=08, disp0=79; viewed_all pulses exactly once, on 3->0.
//  4 Enter rising edge and dataR_valid (dataR=32'h00000055) in the same cycle, byte_sel=2
//    -> byte_sel=0, disp1=12, disp0=12, no viewed_all.
//  5 Reset driven low asynchronously mid-SHOW, between clock edges -> outputs return to reset values
//    before the next clk edge.
//  6 AUTOSCROLL_EN, SCROLL_CYCLES=8: after load, no enter -> byte_sel increments every 8 cycles;
//    viewed_all pulses at cycle 32.

Source files
------------

// File: rtl/result_display_unit.sv
// -----------------------------------------------------------------------------
// result_display_unit
//
// Captures the 32-bit datapath result and shows it one byte at a time on four
// active-low 7-segment displays. The user steps through bytes 0..3 with the
// enter button. Layout while showing:
//   disp3 = byte index, disp2 = 'r', disp1 = high nibble, disp0 = low nibble.
//
// Optional feature: define AUTOSCROLL_EN to advance the byte automatically
// every SCROLL_CYCLES clocks. Without it the counter logic is absent.
//
// Ports
//   clk          in   1   system clock, all state on posedge
//   reset        in   1   asynchronous, active-low reset
//   enter        in   1   raw button level, asynchronous to clk
//   dataR        in   32  result word from datapath
//   dataR_valid  in   1   1-cycle strobe: capture dataR
//   byte_sel     out  2   index of the byte currently displayed
//   showing      out  1   high while in SHOW
//   viewed_all   out  1   1-cycle pulse when stepping past byte 3
//   disp3..disp0 out  7   segments {g,f,e,d,c,b,a}, active-low; disp3 leftmost
// -----------------------------------------------------------------------------
module result_display_unit #(
   parameter int SCROLL_CYCLES = 50_000_000,
   parameter int CNT_W         = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enter,
   input  logic [31:0] dataR,
   input  logic        dataR_valid,
   output logic [1:0]  byte_sel,
   output logic        showing,
   output logic        viewed_all,
   output logic [6:0]  disp3,
   output logic [6:0]  disp2,
   output logic [6:0]  disp1,
   output logic [6:0]  disp0
);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t      state_q, state_d;
   logic [31:0] shadow_q;
   logic        enter_p0, enter_p1, enter_p2;
   logic        step;
   logic        advance;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   // --- enter synchronizer (p0, p1) and edge-detect delay (p2) ---
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enter_p0 <= 1'b0;
         enter_p1 <= 1'b0;
         enter_p2 <= 1'b0;
      end else begin
         enter_p0 <= enter;
         enter_p1 <= enter_p0;
         enter_p2 <= enter_p1;
      end
   end

   assign step = enter_p1 & ~enter_p2;

`ifdef AUTOSCROLL_EN
   logic [CNT_W-1:0] cnt_q;
   logic             auto_adv;

   assign auto_adv = (state_q == SHOW) && (cnt_q == CNT_W'(SCROLL_CYCLES - 1));

   // Any advance (manual or automatic) restarts the interval; IDLE pins it at 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (dataR_valid || (state_q != SHOW) || step || auto_adv) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // A load in the same cycle overrides any advance.
   assign advance = (state_q == SHOW) && !dataR_valid && (step || auto_adv);
`else
   logic unused_cfg;
   assign unused_cfg = ^{SCROLL_CYCLES[0], CNT_W[0]};

   assign advance = (state_q == SHOW) && !dataR_valid && step;
`endif

   always_comb begin
      state_d = state_q;
      if (dataR_valid) begin
         state_d = SHOW;
      end
   end

   // --- control and shadow registers ---
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         byte_sel   <= 2'd0;
         viewed_all <= 1'b0;
      end else begin
         state_q    <= state_d;
         viewed_all <= advance && (byte_sel == 2'd3);
         if (dataR_valid) begin
            shadow_q <= dataR;
            byte_sel <= 2'd0;
         end else if (advance) begin
            byte_sel <= byte_sel + 2'd1;
         end
      end
   end

   assign showing = (state_q == SHOW);

   // --- display decode (combinational from registered state) ---
   always_comb begin
      disp3 = 7'h7F;
      disp2 = 7'h7F;
      disp1 = 7'h7F;
      disp0 = 7'h7F;
      if (state_q == SHOW) begin
         disp3 = hex7({2'b00, byte_sel});
         disp2 = 7'h2F;
         disp1 = hex7(shadow_q[{byte_sel, 3'b100} +: 4]);
         disp0 = hex7(shadow_q[{byte_sel, 3'b000} +: 4]);
      end
   end

endmodule

// File: tb/tb_result_display_unit.sv
module tb_result_display_unit;

   localparam int SC = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enter = 1'b0;
   logic [31:0] dataR = 32'h0;
   logic        dataR_valid = 1'b0;
   logic [1:0]  byte_sel;
   logic        showing;
   logic        viewed_all;
   logic [6:0]  disp3, disp2, disp1, disp0;

   int errors = 0;
   int checks = 0;

   result_display_unit #(.SCROLL_CYCLES(SC), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .enter(enter), .dataR(dataR), .dataR_valid(dataR_valid),
      .byte_sel(byte_sel), .showing(showing), .viewed_all(viewed_all),
      .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish (got running, need finished)");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   bit          m_show;
   logic [31:0] m_shadow;
   int          m_sel;
   bit          m_va;
   int          m_cnt;
   bit          hist[$];   // enter levels seen at the last three edges, oldest first
   int          va_count;

   task automatic model_reset();
      m_show = 0; m_shadow = 0; m_sel = 0; m_va = 0; m_cnt = 0;
      hist = '{0, 0, 0};
   endtask

   // A rising edge of enter takes effect two edges after it is first sampled.
   task automatic model_edge();
      bit st, adv;
      st = hist[1] && !hist[0];
      m_va = 0;
      if (dataR_valid) begin
         m_shadow = dataR; m_sel = 0; m_show = 1; m_cnt = 0;
      end else if (m_show) begin
         adv = st;
`ifdef AUTOSCROLL_EN
         if (m_cnt == SC - 1) begin adv = 1; m_cnt = 0; end
         else if (st) m_cnt = 0;
         else m_cnt = m_cnt + 1;
`endif
         if (adv) begin
            if (m_sel == 3) m_va = 1;
            m_sel = (m_sel + 1) % 4;
         end
      end
      hist.push_back(enter);
      void'(hist.pop_front());
   endtask

   function automatic logic [6:0] exp_disp(int idx);
      logic [7:0] b;
      b = 8'((m_shadow >> (8 * m_sel)) & 32'hFF);
      if (!m_show) return 7'h7F;
      case (idx)
         3: return seg_tab[m_sel];
         2: return 7'h2F;
         1: return seg_tab[b[7:4]];
         default: return seg_tab[b[3:0]];
      endcase
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("showing", 32'(showing), 32'(m_show));
      check("byte_sel", 32'(byte_sel), 32'(m_sel));
      check("viewed_all", 32'(viewed_all), 32'(m_va));
      check("disp3", 32'(disp3), 32'(exp_disp(3)));
      check("disp2", 32'(disp2), 32'(exp_disp(2)));
      check("disp1", 32'(disp1), 32'(exp_disp(1)));
      check("disp0", 32'(disp0), 32'(exp_disp(0)));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (viewed_all) va_count++;
      compare_all();
   endtask

   task automatic press(int hi, int lo);
      enter = 1'b1;
      repeat (hi) tick();
      enter = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic load(logic [31:0] w);
      dataR = w; dataR_valid = 1'b1;
      tick();
      dataR_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int hold;
      model_reset();
      va_count = 0;

      // reset held 3 cycles then released
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      compare_all();
      check("rst_disp0", 32'(disp0), 32'h7F);
      check("rst_showing", 32'(showing), 32'h0);

      // step while IDLE is ignored
      press(3, 3);

`ifndef AUTOSCROLL_EN
      // load and step through all four bytes
      load(32'hA1B2C3F0);
      check("ld_disp3", 32'(disp3), 32'h40);
      check("ld_disp1", 32'(disp1), 32'h0E);
      check("ld_disp0", 32'(disp0), 32'h40);
      va_count = 0;
      repeat (3) press(5, 5);
      check("b3_sel", 32'(byte_sel), 32'd3);
      check("b3_disp1", 32'(disp1), 32'h08);
      check("b3_disp0", 32'(disp0), 32'h79);
      check("b3_va_count", 32'(va_count), 32'd0);
      press(5, 5);
      check("wrap_sel", 32'(byte_sel), 32'd0);
      check("va_once", 32'(va_count), 32'd1);

      // enter edge coinciding with load, byte_sel=2
      press(5, 5);
      press(5, 5);
      check("pre_sel", 32'(byte_sel), 32'd2);
      va_count = 0;
      enter = 1'b1;
      tick();
      tick();
      dataR = 32'h00000055; dataR_valid = 1'b1;
      tick();
      dataR_valid = 1'b0;
      check("coll_sel", 32'(byte_sel), 32'd0);
      check("coll_disp1", 32'(disp1), 32'h12);
      check("coll_disp0", 32'(disp0), 32'h12);
      repeat (3) tick();
      enter = 1'b0;
      repeat (3) tick();
      check("coll_va", 32'(va_count), 32'd0);
`else
      // auto advance every SC cycles, viewed_all at cycle 32
      begin
         int va_at;
         va_at = -1;
         load(32'h12345678);
         for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 8) check("auto_sel8", 32'(byte_sel), 32'd1);
            if (viewed_all && va_at < 0) va_at = i;
         end
         check("auto_va_cycle", 32'(va_at), 32'd32);
      end
`endif

      // asynchronous reset between clock edges
      @(posedge clk);
      #2;
      reset = 1'b0;
      enter = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("async_disp3", 32'(disp3), 32'h7F);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // randomized traffic
      hold = 0;
      for (int n = 0; n < 1500; n++) begin
         if (hold == 0) begin
            enter = ~enter;
            hold = $urandom_range(1, 6);
         end
         hold--;
         dataR = $urandom;
         dataR_valid = ($urandom_range(0, 39) == 0);
         tick();
      end
      dataR_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
